// File: rtl/riscv_lsu.sv
// riscv_lsu: RV32 load/store unit in front of a word-organised data memory.
// Optional macro MISALIGN_TRAP_EN: report misaligned accesses instead of aligning them.
module riscv_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [31:0]           i_inst,
    input  logic [31:0]           i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_mem_wen,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_rsp_err
);
    localparam int AW = ADDR_WIDTH + 2;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t                r_state;
    state_t                w_next;
    logic [AW-1:0]         r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_old;
    logic [2:0]            r_funct3;
    size_t                 r_size;
    logic                  r_load;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;

    logic                  w_accept;
    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_mis;
    size_t                 w_size;
    logic [AW-1:0]         w_addr_al;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_ld_ext;
    logic [DATA_WIDTH-1:0] w_merge;
    logic                  w_unused;

    assign w_unused   = ^{i_inst[31:15], i_inst[11:7], i_addr[31:AW]};
    assign w_is_load  = (i_inst[6:0] == OP_LOAD);
    assign w_is_store = (i_inst[6:0] == OP_STORE);
    assign w_accept   = i_req_valid && o_req_ready;

    always_comb begin
        w_size = SZ_W;
        case (i_inst[13:12])
            2'b00:   w_size = SZ_B;
            2'b01:   w_size = SZ_H;
            default: w_size = SZ_W;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign w_mis = (w_is_load || w_is_store) &&
                   (((w_size == SZ_H) && i_addr[0]) ||
                    ((w_size == SZ_W) && (i_addr[1:0] != 2'b00)));
    assign w_addr_al = i_addr[AW-1:0];
`else
    // Misaligned requests are silently pulled down to natural alignment.
    assign w_mis = 1'b0;
    assign w_addr_al = {i_addr[AW-1:2],
                        (w_size == SZ_W) ? 1'b0 : i_addr[1],
                        (w_size == SZ_B) ? i_addr[0] : 1'b0};
`endif

    assign w_byte = i_mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = i_mem_rdata[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_ld_ext = i_mem_rdata;
        case (r_funct3)
            3'b000:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_ext = {24'd0, w_byte};
            3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_ext = {16'd0, w_half};
            default: w_ld_ext = i_mem_rdata;
        endcase
    end

    // Sub-word stores overlay the new lane onto the word captured in READ.
    always_comb begin
        w_merge = r_old;
        case (r_size)
            SZ_B:    w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            SZ_H:    w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merge = r_wdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_req_ready = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_wdata = '0;
        o_rsp_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (!(w_is_load || w_is_store) || w_mis)
                        w_next = S_RESP;
                    else if (w_is_store && (w_size == SZ_W))
                        w_next = S_WRITE;
                    else
                        w_next = S_READ;
                end
            end
            S_READ:  w_next = r_load ? S_RESP : S_WRITE;
            S_WRITE: begin
                o_mem_wen   = 1'b1;
                o_mem_wdata = w_merge;
                w_next      = S_RESP;
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_old      <= '0;
            r_funct3   <= '0;
            r_size     <= SZ_B;
            r_load     <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= w_addr_al;
                r_wdata  <= i_wdata;
                r_funct3 <= i_inst[14:12];
                r_size   <= w_size;
                r_load   <= w_is_load;
            end
            if (r_state == S_READ) r_old <= i_mem_rdata;
            if ((w_next == S_RESP) && (r_state != S_RESP)) begin
                r_rsp_data <= ((r_state == S_READ) && r_load) ? w_ld_ext : '0;
                r_rsp_err  <= (r_state == S_IDLE) && w_mis;
            end
        end
    end

    assign o_mem_addr = r_addr[AW-1:2];
    assign o_rsp_data = r_rsp_data;
    assign o_rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed vector bench for riscv_lsu with a small word memory.
// Expectations follow MISALIGN_TRAP_EN when it is defined for the build.
module tb_riscv_lsu;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] OP = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [31:0] i_inst = '0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic        o_mem_wen;
    logic [14:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;

    logic [31:0] mem [64];
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    riscv_lsu dut (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_inst(i_inst), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
        .o_rsp_err(o_rsp_err)
    );

    assign i_mem_rdata = mem[o_mem_addr[5:0]];

    always @(posedge clk)
        if (o_mem_wen) mem[o_mem_addr[5:0]] <= o_mem_wdata;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          pre_en;
        int          pre_idx;
        logic [31:0] pre_val;
        logic [31:0] exp_d;
        logic        exp_e;
        int          exp_c;
        int          exp_w;
        logic [14:0] exp_ma;
        bit          post_en;
        int          post_idx;
        logic [31:0] post_val;
    } vec_t;

    vec_t vt[18];

    function automatic logic [31:0] ins(input logic [2:0] f3, input logic [6:0] op);
        return {17'd0, f3, 5'd0, op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_op(input logic [31:0] inst, input logic [31:0] addr,
                          input logic [31:0] wdata,
                          output logic [31:0] d, output logic e,
                          output int cyc, output int wens, output logic [14:0] ma);
        @(negedge clk);
        i_req_valid = 1'b1;
        i_inst = inst;
        i_addr = addr;
        i_wdata = wdata;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        i_inst = '0;
        i_addr = '0;
        i_wdata = '0;
        cyc = 1;
        wens = 0;
        while (!o_rsp_valid && cyc < 10) begin
            if (o_mem_wen) wens++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (o_mem_wen) wens++;
        d = o_rsp_data;
        e = o_rsp_err;
        ma = o_mem_addr;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          cyc;
        int          wens;
        logic [14:0] ma;

        for (int i = 0; i < 64; i++) mem[i] = '0;

        vt[0]  = '{"lb_neg", ins(3'b000, LD), 32'h14, 0, 1, 5, 32'h8000_00F0,
                   32'hFFFF_FFF0, 0, 2, 0, 15'd5, 0, 0, 0};
        vt[1]  = '{"lbu", ins(3'b100, LD), 32'h14, 0, 0, 0, 0,
                   32'h0000_00F0, 0, 2, 0, 15'd5, 0, 0, 0};
        vt[2]  = '{"sb_lane2", ins(3'b000, ST), 32'h16, 32'hFFFF_FFAB, 1, 5, 32'h1122_3344,
                   0, 0, 3, 1, 15'd5, 1, 5, 32'h11AB_3344};
        vt[3]  = '{"sh_hi", ins(3'b001, ST), 32'h0A, 32'h0000_1234, 1, 2, 32'hDEAD_BEEF,
                   0, 0, 3, 1, 15'd2, 1, 2, 32'h1234_BEEF};
        vt[4]  = '{"lh_hi", ins(3'b001, LD), 32'h0A, 0, 0, 0, 0,
                   32'h0000_1234, 0, 2, 0, 15'd2, 0, 0, 0};
        vt[5]  = '{"lh_neg", ins(3'b001, LD), 32'h08, 0, 0, 0, 0,
                   32'hFFFF_BEEF, 0, 2, 0, 15'd2, 0, 0, 0};
        vt[6]  = '{"lhu", ins(3'b101, LD), 32'h08, 0, 0, 0, 0,
                   32'h0000_BEEF, 0, 2, 0, 15'd2, 0, 0, 0};
        vt[7]  = '{"sw", ins(3'b010, ST), 32'h20, 32'hCAFE_F00D, 0, 0, 0,
                   0, 0, 2, 1, 15'd8, 1, 8, 32'hCAFE_F00D};
        vt[8]  = '{"lw_mis", ins(3'b010, LD), 32'h21, 0, 0, 0, 0,
                   TRAP ? 32'h0 : 32'hCAFE_F00D, TRAP, TRAP ? 1 : 2, 0, 15'd8, 0, 0, 0};
        vt[9]  = '{"lb_lane3", ins(3'b000, LD), 32'h0F, 0, 1, 3, 32'h7F00_0080,
                   32'h0000_007F, 0, 2, 0, 15'd3, 0, 0, 0};
        vt[10] = '{"lb_lane0", ins(3'b000, LD), 32'h0C, 0, 0, 0, 0,
                   32'hFFFF_FF80, 0, 2, 0, 15'd3, 0, 0, 0};
        vt[11] = '{"other_op", ins(3'b000, OP), 32'h10, 32'h5555_5555, 1, 4, 32'h0BAD_0BAD,
                   0, 0, 1, 0, 15'd4, 1, 4, 32'h0BAD_0BAD};
        vt[12] = '{"lw_wrap", ins(3'b010, LD), 32'h0002_0014, 0, 0, 0, 0,
                   32'h11AB_3344, 0, 2, 0, 15'd5, 0, 0, 0};
        vt[13] = '{"sh_mis", ins(3'b001, ST), 32'h0B, 32'h0000_5555, 0, 0, 0,
                   0, TRAP, TRAP ? 1 : 3, TRAP ? 0 : 1, 15'd2,
                   1, 2, TRAP ? 32'h1234_BEEF : 32'h5555_BEEF};
        vt[14] = '{"ld_f3_011", ins(3'b011, LD), 32'h20, 0, 0, 0, 0,
                   32'hCAFE_F00D, 0, 2, 0, 15'd8, 0, 0, 0};
        vt[15] = '{"sb_lane0", ins(3'b000, ST), 32'h20, 32'h0000_0011, 0, 0, 0,
                   0, 0, 3, 1, 15'd8, 1, 8, 32'hCAFE_F011};
        vt[16] = '{"lh_mis", ins(3'b001, LD), 32'h23, 0, 0, 0, 0,
                   TRAP ? 32'h0 : 32'hFFFF_CAFE, TRAP, TRAP ? 1 : 2, 0, 15'd8, 0, 0, 0};
        vt[17] = '{"sw_mis", ins(3'b010, ST), 32'h26, 32'h0102_0304, 1, 9, 32'h0,
                   0, TRAP, TRAP ? 1 : 2, TRAP ? 0 : 1, 15'd9,
                   1, 9, TRAP ? 32'h0 : 32'h0102_0304};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, o_req_ready}, 32'd1);
        chk("rst_wen", {31'd0, o_mem_wen}, 32'd0);
        chk("rst_maddr", {17'd0, o_mem_addr}, 32'd0);
        chk("rst_wdata", o_mem_wdata, 32'd0);
        chk("rst_rspv", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst_rspd", o_rsp_data, 32'd0);
        chk("rst_rspe", {31'd0, o_rsp_err}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            if (vt[i].pre_en) mem[vt[i].pre_idx] = vt[i].pre_val;
            run_op(vt[i].inst, vt[i].addr, vt[i].wdata, d, e, cyc, wens, ma);
            chk({vt[i].name, "_data"}, d, vt[i].exp_d);
            chk({vt[i].name, "_err"}, {31'd0, e}, {31'd0, vt[i].exp_e});
            chk({vt[i].name, "_lat"}, cyc, vt[i].exp_c);
            chk({vt[i].name, "_wen"}, wens, vt[i].exp_w);
            chk({vt[i].name, "_maddr"}, {17'd0, ma}, {17'd0, vt[i].exp_ma});
            @(posedge clk);
            #1;
            chk({vt[i].name, "_pulse"}, {30'd0, o_rsp_valid, o_req_ready}, 32'd1);
            chk({vt[i].name, "_hold"}, o_rsp_data, vt[i].exp_d);
            if (vt[i].post_en)
                chk({vt[i].name, "_mem"}, mem[vt[i].post_idx], vt[i].post_val);
        end

        // reset while an SB sits in READ: nothing may be written or answered
        mem[5] = 32'h11AB_3344;
        @(negedge clk);
        i_req_valid = 1'b1;
        i_inst = ins(3'b000, ST);
        i_addr = 32'h14;
        i_wdata = 32'h99;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        chk("rmw_busy", {31'd0, o_req_ready}, 32'd0);
        chk("rmw_in_read", {30'd0, o_mem_wen, o_rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rmw_rst_ready", {31'd0, o_req_ready}, 32'd1);
        chk("rmw_rst_outs", {30'd0, o_mem_wen, o_rsp_valid}, 32'd0);
        chk("rmw_rst_rspd", o_rsp_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wens = 0;
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (o_mem_wen) wens++;
            if (o_rsp_valid) cyc++;
        end
        chk("rmw_no_wen", wens, 0);
        chk("rmw_no_rsp", cyc, 0);
        chk("rmw_mem", mem[5], 32'h11AB_3344);

        run_op(ins(3'b100, LD), 32'h14, 0, d, e, cyc, wens, ma);
        chk("post_rst_lbu", d, 32'h0000_0044);
        chk("post_rst_lat", cyc, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
